demux_32_1x2_buf: RTL
=====================

Name: demux_32_1x2_buf

Overview:
- Registered 1-to-2 demultiplexer, the inverse of the 2-to-1 word mux used on the datapath.
- Takes one WIDTH-bit valid/ready stream plus a select bit and steers each word to one of two output streams.
- Each output has a one-entry holding register and its own back-pressure. Transfer counters are kept per port.
- Sits between a single producer (e.g. writeback/result bus) and two independent consumers.

Parameters:
WIDTH, 32, data word width in bits
CNT_W, 16, width of per-port transfer counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
in_data  input  WIDTH  word to route
in_select  input  1  destination: 0 -> port 0, 1 -> port 1
in_valid  input  1  in_data/in_select are valid
in_ready  output  1  block accepts the word this cycle
out0_data  output  WIDTH  port 0 word
out0_valid  output  1  port 0 holds a word
out0_ready  input  1  port 0 consumer accepts
out1_data  output  WIDTH  port 1 word
out1_valid  output  1  port 1 holds a word
out1_ready  input  1  port 1 consumer accepts
count0  output  CNT_W  completed port 0 transfers
count1  output  CNT_W  completed port 1 transfers

Behaviour:
Reset:
- One clock, synchronous, active-low.
- On a rising edge with reset_n=0: out0_valid=out1_valid=0, out0_data=out1_data=0, count0=count1=0.
- While reset_n=0, in_ready=0 combinationally.
- Reset mid-operation discards held words without completing them. Counters do not increment on that edge.

Per-port state machine (port p), independent of the other port:
- EMPTY (outp_valid=0) and FULL (outp_valid=1).
- accept_p = in_valid & in_ready & (in_select==p); drain_p = outp_valid & outp_ready.
- EMPTY + accept_p -> FULL; outp_data <= in_data.
- FULL + drain_p & !accept_p -> EMPTY.
- FULL + drain_p & accept_p -> FULL, with new data loaded. This gives back-to-back throughput of 1 word/cycle per port.
- FULL + !drain_p -> FULL; outp_data and outp_valid held stable until drained. A word is never dropped or overwritten.

Input handshake:
- in_ready = reset_n & (out_sel_valid==0 | out_sel_ready), where sel = in_select.
- in_ready is combinational from in_select, outX_valid and outX_ready. No combinational path from in_valid to in_ready.
- in_ready may be high with in_valid low; no state change results.
- A stall on one port does not block words destined for the other port.

Latency and ordering:
- A word accepted on edge N is presented on its port from edge N onward, i.e. visible the following cycle.
- Words to the same port are delivered in acceptance order.
- No ordering relation between ports.

Counters:
- countp increments by 1 on each edge where drain_p=1 (and reset_n=1).
- Counters wrap modulo 2^CNT_W, e.g. 16'hFFFF -> 16'h0000. No saturation, no flag.
- Simultaneous drains on both ports increment both counters.

Unused data:
- out data registers are not cleared on drain; they retain the last word.
- Consumers must qualify data with valid.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with in_valid=1 -> in_ready=0, both valids 0, both counts 0, both data 0.
- Basic routing: in_data=32'hDEADBEEF, sel=0, out0_ready=1 -> out0_valid=1 next cycle with data DEADBEEF, out1_valid stays 0, count0=1 after the drain edge. Repeat with 32'h12345678, sel=1 -> port 1, count1=1.
- Back-pressure: out1_ready=0, send 32'hA5A5A5A5 to port 1. Then offer 32'h5A5A5A5A to port 1 -> in_ready=0, out1_data holds A5A5A5A5 for 5 cycles. Meanwhile 32'h00000007 to port 0 is accepted. Raise out1_ready -> A5A5A5A5 drains, then 5A5A5A5A is accepted.
- Streaming: 8 words 1..8 with alternating sel and both ready=1 -> in_ready=1 every cycle, port 0 sees 1,3,5,7, port 1 sees 2,4,6,8 in order, count0=count1=4.
- Full+drain+refill: port 0 FULL, out0_ready=1, new word 32'hCAFEF00D to port 0 on the same edge -> out0_valid stays 1, data becomes CAFEF00D, count0 +1.
- Wrap / reset mid-flight: preload via 65535 port 0 drains, one more drain -> count0=0. Then hold a word in port 1 and assert reset_n=0 for one edge -> out1_valid=0, count1 unchanged from 0.

Source files
------------

// File: rtl/demux_32_1x2_buf.sv
// rtl/demux_32_1x2_buf.sv - registered 1-to-2 stream demultiplexer with per-port holding register and transfer counter

module demux_32_1x2_buf_slot #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state;
    logic   drain;

    assign drain = (state == ST_FULL) & ready;
    assign valid = (state == ST_FULL);

    // Data register is not cleared on drain; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
            data  <= '0;
            count <= '0;
        end else begin
            if (drain) begin
                count <= count + CNT_W'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (load) begin
                        state <= ST_FULL;
                        data  <= load_data;
                    end
                end
                ST_FULL: begin
                    if (load) begin
                        data <= load_data;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

module demux_32_1x2_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    logic space0;
    logic space1;
    logic accept0;
    logic accept1;

    // A full slot can take a new word on the same edge it drains.
    assign space0   = ~out0_valid | out0_ready;
    assign space1   = ~out1_valid | out1_ready;
    assign in_ready = reset_n & (in_select ? space1 : space0);
    assign accept0  = in_valid & in_ready & ~in_select;
    assign accept1  = in_valid & in_ready & in_select;

    demux_32_1x2_buf_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept0),
        .load_data(in_data),
        .data     (out0_data),
        .valid    (out0_valid),
        .ready    (out0_ready),
        .count    (count0)
    );

    demux_32_1x2_buf_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept1),
        .load_data(in_data),
        .data     (out1_data),
        .valid    (out1_valid),
        .ready    (out1_ready),
        .count    (count1)
    );

endmodule
